apb_master_sequencer: RTL and testbench

//  APB initiator that issues the CONFIG/TX/CMD/STATUS/RX transfers the APB_interface_2 slave expects.

---
 rtl/apb_master_pkg.sv | 12 +
 rtl/apb_cmd_fifo.sv | 33 +++
 rtl/apb_master_sequencer.sv | 92 +++++++++
 tb/tb_apb_master_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared FSM encoding, slave register map and command layout
package apb_master_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    localparam logic [15:0] ADDR_CONFIG = 16'h0040;
    localparam logic [15:0] ADDR_TXRX   = 16'h0044;
    localparam logic [15:0] ADDR_CMD    = 16'h004C;
    localparam int CMD_WRITE_W = 1;
    localparam int CNT_W = 8;
    function automatic int cmd_width(input int aw, input int dw);
        return CMD_WRITE_W + aw + dw;
    endfunction
endpackage

// File: rtl/apb_cmd_fifo.sv
// apb_cmd_fifo: synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty
module apb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/apb_master_sequencer.sv
// apb_master_sequencer: drains queued {write, addr, wdata} commands as APB SETUP/ACCESS transfers
// and returns one response (read data, timeout flag) per command in push order.
module apb_master_sequencer
    import apb_master_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_PCLK,
    input  logic              i_PRESETn,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_PSEL0,
    output logic              o_PENABLE,
    output logic              o_PWRITE,
    output logic [ADDR_W-1:0] o_PADDR,
    output logic [DATA_W-1:0] o_PWDATA,
    input  logic              i_PREADY,
    input  logic [DATA_W-1:0] i_PRDATA,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_busy
);
    localparam int CMD_W = cmd_width(ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CMD_W-1:0] head;
    logic full, empty, pop, done, abort;
    apb_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
        .clk(i_PCLK),
        .rst_n(i_PRESETn),
        .push(i_cmd_valid),
        .wdata({i_cmd_write, i_cmd_addr, i_cmd_wdata}),
        .pop(pop),
        .rdata(head),
        .full(full),
        .empty(empty)
    );
    assign o_cmd_ready = !full;
    assign o_PSEL0     = state != IDLE;
    assign o_PENABLE   = state == ACCESS;
    assign o_busy      = !empty || state != IDLE;
    assign done        = state == ACCESS && i_PREADY;
    // The abort edge is the last ACCESS cycle, so ACCESS lasts exactly TIMEOUT_CYC cycles.
    assign abort       = state == ACCESS && !i_PREADY && cnt == CNT_LAST;
    always_comb begin
        state_nx = state;
        pop = 1'b0;
        case (state)
            IDLE: begin
                pop = !empty;
                state_nx = empty ? IDLE : SETUP;
            end
            SETUP: state_nx = ACCESS;
            ACCESS: begin
                pop = done && !empty;
                state_nx = done ? (empty ? IDLE : SETUP) : abort ? IDLE : ACCESS;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state       <= IDLE;
            cnt         <= '0;
            o_PWRITE    <= 1'b0;
            o_PADDR     <= '0;
            o_PWDATA    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (pop) begin
                o_PWRITE <= head[CMD_W-1];
                o_PADDR  <= head[ADDR_W+DATA_W-1:DATA_W];
                o_PWDATA <= head[CMD_W-1] ? head[DATA_W-1:0] : '0;
            end
            cnt <= state == SETUP ? '0 : (state == ACCESS && !i_PREADY) ? cnt + CNT_W'(1) : cnt;
            o_rsp_valid <= done || abort;
            o_rsp_err   <= abort;
            if (done || abort) o_rsp_rdata <= (done && !o_PWRITE) ? i_PRDATA : '0;
        end
    end
endmodule

// File: tb/tb_apb_master_sequencer.sv
// tb_apb_master_sequencer: directed vectors with hand-computed expectations for the APB sequencer
module tb_apb_master_sequencer;
    import apb_master_pkg::*;
    typedef struct packed {logic w; logic [15:0] a; logic [7:0] d;} cmd_t;
    logic        i_PCLK = 1'b0;
    logic        i_PRESETn;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [15:0] i_cmd_addr;
    logic [7:0]  i_cmd_wdata;
    logic        o_PSEL0, o_PENABLE, o_PWRITE;
    logic [15:0] o_PADDR;
    logic [7:0]  o_PWDATA;
    logic        i_PREADY;
    logic [7:0]  i_PRDATA;
    logic        o_rsp_valid;
    logic [7:0]  o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_busy;
    int checks = 0;
    int failures = 0;
    cmd_t pend[$];
    logic [15:0] done_a[$];
    logic [7:0]  done_d[$];
    logic [7:0]  rsp_d[$];
    logic        rsp_e[$];
    int n_setup, n_en, gap, stall_push;
    logic ready_one;
    apb_master_sequencer dut (
        .i_PCLK(i_PCLK), .i_PRESETn(i_PRESETn),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_PSEL0(o_PSEL0), .o_PENABLE(o_PENABLE), .o_PWRITE(o_PWRITE),
        .o_PADDR(o_PADDR), .o_PWDATA(o_PWDATA),
        .i_PREADY(i_PREADY), .i_PRDATA(i_PRDATA),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_busy(o_busy)
    );
    always #5 i_PCLK = ~i_PCLK;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Feeds pend[] into the DUT and logs bus activity for n cycles; the first transfer stalls for hold ACCESS cycles.
    task automatic watch(input int n, input int hold);
        int acc_run = 0;
        int xfer = 0;
        logic took = 1'b0;
        logic seen1 = 1'b0;
        logic started = 1'b0;
        n_setup = 0; n_en = 0; gap = 0; stall_push = 0; ready_one = 1'b1;
        done_a.delete(); done_d.delete(); rsp_d.delete(); rsp_e.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge i_PCLK);
            if (took) void'(pend.pop_front());
            if (o_PSEL0 && !o_PENABLE) xfer++;
            acc_run = o_PENABLE ? acc_run + 1 : 0;
            i_PREADY = (xfer != 1) || (acc_run > hold);
            if (o_PSEL0) started = 1'b1;
            if (started && !o_PSEL0 && o_busy) gap++;
            if (o_PSEL0 && !o_PENABLE) n_setup++;
            if (o_PENABLE) n_en++;
            if (o_PENABLE && i_PREADY) begin
                done_a.push_back(o_PADDR);
                done_d.push_back(o_PWDATA);
            end
            if (o_rsp_valid) begin
                rsp_d.push_back(o_rsp_rdata);
                rsp_e.push_back(o_rsp_err);
            end
            i_cmd_valid = pend.size() != 0;
            if (i_cmd_valid) {i_cmd_write, i_cmd_addr, i_cmd_wdata} = pend[0];
            took = i_cmd_valid && o_cmd_ready;
            if (i_cmd_valid && !o_cmd_ready) stall_push++;
            if (pend.size() == 1 && !seen1) begin
                seen1 = 1'b1;
                ready_one = o_cmd_ready;
            end
        end
        i_cmd_valid = 1'b0;
    endtask
    initial begin
        i_PRESETn = 1'b0;
        i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
        i_PREADY = 1'b1; i_PRDATA = '0;
        repeat (2) @(negedge i_PCLK);
        check("rst_psel", o_PSEL0, 0);
        check("rst_penable", o_PENABLE, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_cmd_ready", o_cmd_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_paddr", o_PADDR, 0);
        i_PRESETn = 1'b1;
        @(negedge i_PCLK);
        // single write, PREADY tied high
        i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = ADDR_CONFIG; i_cmd_wdata = 8'h05;
        @(negedge i_PCLK);
        i_cmd_valid = 1'b0;
        check("w1_idle_after_push", o_PSEL0, 0);
        check("w1_busy", o_busy, 1);
        @(negedge i_PCLK);
        check("w1_setup_psel", o_PSEL0, 1);
        check("w1_setup_penable", o_PENABLE, 0);
        check("w1_paddr", o_PADDR, 16'h0040);
        check("w1_pwdata", o_PWDATA, 8'h05);
        check("w1_pwrite", o_PWRITE, 1);
        @(negedge i_PCLK);
        check("w1_access_penable", o_PENABLE, 1);
        check("w1_no_early_rsp", o_rsp_valid, 0);
        @(negedge i_PCLK);
        check("w1_rsp_valid", o_rsp_valid, 1);
        check("w1_rsp_err", o_rsp_err, 0);
        check("w1_rsp_rdata", o_rsp_rdata, 0);
        check("w1_psel_drop", o_PSEL0, 0);
        @(negedge i_PCLK);
        check("w1_rsp_pulse", o_rsp_valid, 0);
        check("w1_idle_busy", o_busy, 0);
        // back-to-back CONFIG/TX/CMD writes
        pend.push_back('{1'b1, ADDR_CONFIG, 8'h0D});
        pend.push_back('{1'b1, ADDR_TXRX, 8'h81});
        pend.push_back('{1'b1, ADDR_CMD, 8'h02});
        watch(12, 0);
        check("b2b_n_done", done_a.size(), 3);
        check("b2b_a0", done_a[0], 16'h0040);
        check("b2b_a1", done_a[1], 16'h0044);
        check("b2b_a2", done_a[2], 16'h004C);
        check("b2b_d0", done_d[0], 8'h0D);
        check("b2b_d1", done_d[1], 8'h81);
        check("b2b_d2", done_d[2], 8'h02);
        check("b2b_setup_cycles", n_setup, 3);
        check("b2b_psel_gap", gap, 0);
        check("b2b_n_rsp", rsp_d.size(), 3);
        // read with 5 wait states
        i_PRDATA = 8'hA5;
        pend.push_back('{1'b0, ADDR_TXRX, 8'hFF});
        watch(15, 5);
        check("rd_enable_cycles", n_en, 6);
        check("rd_pwdata_zero", done_d[0], 0);
        check("rd_n_rsp", rsp_d.size(), 1);
        check("rd_rdata", rsp_d[0], 8'hA5);
        check("rd_err", rsp_e[0], 0);
        // timeout on a stuck slave, then the next queued read runs
        pend.push_back('{1'b0, ADDR_CONFIG, 8'h00});
        pend.push_back('{1'b0, ADDR_TXRX, 8'h00});
        watch(275, 1000);
        check("to_enable_cycles", n_en, 256);
        check("to_n_rsp", rsp_d.size(), 2);
        check("to_err0", rsp_e[0], 1);
        check("to_rdata0", rsp_d[0], 0);
        check("to_err1", rsp_e[1], 0);
        check("to_rdata1", rsp_d[1], 8'hA5);
        check("to_next_addr", done_a[0], 16'h0044);
        // FIFO fills while the first transfer stalls
        i_PRDATA = 8'h3C;
        pend.push_back('{1'b1, ADDR_CONFIG, 8'h11});
        pend.push_back('{1'b1, ADDR_TXRX, 8'h81});
        pend.push_back('{1'b1, ADDR_CMD, 8'h02});
        pend.push_back('{1'b1, ADDR_CONFIG, 8'h0D});
        pend.push_back('{1'b0, ADDR_TXRX, 8'h00});
        pend.push_back('{1'b1, ADDR_TXRX, 8'h7E});
        watch(70, 20);
        check("full_ready_low", ready_one, 0);
        check("full_push_held", stall_push > 0, 1);
        check("full_n_done", done_a.size(), 6);
        check("full_a1", done_a[1], 16'h0044);
        check("full_a3", done_a[3], 16'h0040);
        check("full_a5", done_a[5], 16'h0044);
        check("full_d0", done_d[0], 8'h11);
        check("full_d4", done_d[4], 8'h00);
        check("full_d5", done_d[5], 8'h7E);
        check("full_n_rsp", rsp_d.size(), 6);
        check("full_rsp_read", rsp_d[4], 8'h3C);
        check("full_rsp_write", rsp_d[5], 0);
        // asynchronous reset mid-ACCESS
        i_PRDATA = 8'h00;
        pend.push_back('{1'b0, ADDR_CMD, 8'h00});
        pend.push_back('{1'b1, ADDR_CONFIG, 8'h33});
        watch(6, 1000);
        check("ar_in_access", o_PENABLE, 1);
        #2 i_PRESETn = 1'b0;
        #1;
        check("ar_psel", o_PSEL0, 0);
        check("ar_penable", o_PENABLE, 0);
        check("ar_rsp_valid", o_rsp_valid, 0);
        check("ar_busy", o_busy, 0);
        @(negedge i_PCLK);
        i_PRESETn = 1'b1;
        repeat (3) @(negedge i_PCLK);
        check("ar_busy_after", o_busy, 0);
        check("ar_psel_after", o_PSEL0, 0);
        check("ar_no_rsp", o_rsp_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
